// File: rtl/pwm_main.sv
// Single-channel PWM: free-running period counter, saturating duty register stepped by
// edge-detected inc/dec commands, and a shadow duty loaded only at the period boundary.

module pwm_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] counter;

    // Free-running period counter, wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= {CNT_WIDTH{1'b0}};
        end else begin
            counter <= counter + CNT_WIDTH'(1'b1);
        end
    end

    assign o_count = counter;

endmodule

module pwm_main #(
    parameter int CNT_WIDTH = 8,
    parameter int DUTY_STEP = 64,
    parameter int DUTY_INIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic duty_inc,
    input  logic duty_dec,
    output logic PWM_out
);

    localparam logic [CNT_WIDTH-1:0] DUTY_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH:0]   STEP_EXT = (CNT_WIDTH+1)'(DUTY_STEP);
    localparam logic [CNT_WIDTH-1:0] INIT_VAL = CNT_WIDTH'(DUTY_INIT);

    // The extra top bit of the widened sum is the overflow flag.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] val);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, val} + STEP_EXT;
        if (sum[CNT_WIDTH]) begin
            sat_add = DUTY_MAX;
        end else begin
            sat_add = sum[CNT_WIDTH-1:0];
        end
    endfunction

    // The extra top bit of the widened difference is the borrow flag.
    function automatic logic [CNT_WIDTH-1:0] sat_sub(input logic [CNT_WIDTH-1:0] val);
        logic [CNT_WIDTH:0] diff;
        diff = {1'b0, val} - STEP_EXT;
        if (diff[CNT_WIDTH]) begin
            sat_sub = {CNT_WIDTH{1'b0}};
        end else begin
            sat_sub = diff[CNT_WIDTH-1:0];
        end
    endfunction

    logic [CNT_WIDTH-1:0] w_counter;
    logic                 inc_q;
    logic                 dec_q;
    logic [CNT_WIDTH-1:0] duty_cycle;
    logic [CNT_WIDTH-1:0] duty_active;
    logic                 w_inc_pulse;
    logic                 w_dec_pulse;
    logic [CNT_WIDTH-1:0] w_duty_next;

    pwm_counter #(.CNT_WIDTH(CNT_WIDTH)) counter_inst (
        .clk     (clk),
        .reset   (reset),
        .o_count (w_counter)
    );

    assign w_inc_pulse = duty_inc & ~inc_q;
    assign w_dec_pulse = duty_dec & ~dec_q;

    // Next duty value; simultaneous inc and dec cancel out.
    always_comb begin
        w_duty_next = duty_cycle;
        case ({w_inc_pulse, w_dec_pulse})
            2'b10:   w_duty_next = sat_add(duty_cycle);
            2'b01:   w_duty_next = sat_sub(duty_cycle);
            default: w_duty_next = duty_cycle;
        endcase
    end

    // Edge-detect flops, duty and shadow registers, and the registered PWM output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            duty_cycle  <= INIT_VAL;
            duty_active <= INIT_VAL;
            PWM_out     <= 1'b0;
        end else begin
            inc_q      <= duty_inc;
            dec_q      <= duty_dec;
            duty_cycle <= w_duty_next;
            if (w_counter == DUTY_MAX) begin
                duty_active <= duty_cycle;
            end
            PWM_out <= (w_counter < duty_active);
        end
    end

endmodule

// File: tb/tb_pwm_main.sv
// Bench for pwm_main: table-driven command vectors, a due-cycle scoreboard for duty steps,
// and a per-period high-count monitor aligned to a bench-side counter.

module tb_pwm_main;

    logic clk = 1'b0;
    logic reset;
    logic duty_inc;
    logic duty_dec;
    logic PWM_out;

    pwm_main dut (
        .clk      (clk),
        .reset    (reset),
        .duty_inc (duty_inc),
        .duty_dec (duty_dec),
        .PWM_out  (PWM_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       inc;
        logic       dec;
        int         hold;
        int         gap;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        int         due;
        logic [7:0] val;
    } sb_t;

    sb_t  sbq[$];
    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   armed  = 1'b0;
    bit   aligned;
    int   exp_cnt;
    int   exp_duty;
    int   exp_active;
    int   hi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle model check, called once per negedge from the stimulus process.
    task automatic monitor();
        sb_t e;
        if (!armed) return;
        exp_cnt = (exp_cnt + 1) % 256;
        check("counter", dut.counter_inst.counter, exp_cnt);
        hi += int'(PWM_out);
        if (exp_cnt == 0) begin
            if (aligned) check("period_high", hi, exp_active);
            exp_active = exp_duty;
            hi         = 0;
            aligned    = 1'b1;
        end
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
            check("sb_missed", sbq[0].due, cyc);
            void'(sbq.pop_front());
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            check("duty_step", dut.duty_cycle, e.val);
            exp_duty = int'(e.val);
        end
        check("duty_hold", dut.duty_cycle, exp_duty);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic release_reset();
        repeat (3) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        reset      = 1'b0;
        exp_cnt    = 255;
        exp_duty   = 0;
        exp_active = 0;
        hi         = 0;
        aligned    = 1'b0;
        sbq.delete();
        armed      = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        sb_t e;
        duty_inc = v.inc;
        duty_dec = v.dec;
        e.due = cyc + 1;
        e.val = v.exp;
        sbq.push_back(e);
        repeat (v.hold) tick();
        duty_inc = 1'b0;
        duty_dec = 1'b0;
        repeat (v.gap) tick();
    endtask

    initial begin
        bit   found;
        vec_t v;
        reset    = 1'b1;
        duty_inc = 1'b0;
        duty_dec = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 1,  100, 8'd64};
        vecs[1]  = '{1'b1, 1'b0, 1,  100, 8'd128};
        vecs[2]  = '{1'b1, 1'b0, 1,  300, 8'd192};
        vecs[3]  = '{1'b0, 1'b1, 1,  100, 8'd128};
        vecs[4]  = '{1'b0, 1'b1, 1,  100, 8'd64};
        vecs[5]  = '{1'b0, 1'b1, 1,  100, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 1,  600, 8'd0};
        vecs[7]  = '{1'b1, 1'b0, 10, 10,  8'd64};
        vecs[8]  = '{1'b1, 1'b0, 10, 10,  8'd128};
        vecs[9]  = '{1'b1, 1'b0, 10, 10,  8'd192};
        vecs[10] = '{1'b1, 1'b0, 10, 10,  8'd255};
        vecs[11] = '{1'b1, 1'b0, 10, 600, 8'd255};
        vecs[12] = '{1'b1, 1'b1, 1,  300, 8'd255};

        // Reset state while reset is held.
        @(negedge clk);
        check("rst_counter", dut.counter_inst.counter, 0);
        check("rst_duty", dut.duty_cycle, 0);
        check("rst_active", dut.duty_active, 0);
        check("rst_edge_q", {dut.inc_q, dut.dec_q}, 0);
        check("rst_pwm", PWM_out, 0);
        release_reset();

        // Idle: counter walks and wraps, output stays low for over two periods.
        repeat (600) tick();

        for (int i = 0; i < 13; i++) drive(vecs[i]);

        // Fresh reset, then a mid-period step issued while counter = 10.
        @(posedge clk);
        #1;
        cyc++;
        armed = 1'b0;
        reset = 1'b1;
        release_reset();
        v = '{1'b1, 1'b0, 1, 300, 8'd64};
        drive(v);
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (dut.counter_inst.counter == 8'd10) found = 1'b1;
            else tick();
        end
        check("wait_cnt10", found, 1);
        v = '{1'b1, 1'b0, 1, 0, 8'd128};
        drive(v);

        // Wait for a full-128 period at counter 50 with the output high, then reset async.
        found = 1'b0;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(negedge clk);
            monitor();
            if (exp_active == 128 && dut.counter_inst.counter == 8'd50 && PWM_out === 1'b1) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check("wait_cnt50", found, 1);
        armed = 1'b0;
        reset = 1'b1;
        #1;
        check("async_pwm", PWM_out, 0);
        check("async_counter", dut.counter_inst.counter, 0);
        check("async_duty", dut.duty_cycle, 0);
        release_reset();
        repeat (600) tick();
        check("post_rst_duty", dut.duty_cycle, 0);

        check("sb_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
